// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    RESP
  } dcache_state_t;

  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_BITS    = 2;

  // Number of index bits for a cache of 'sets' lines.
  function automatic int idx_bits(input int sets);
    return $clog2(sets);
  endfunction

  // Tag bits = address bits above index, word offset and byte offset.
  function automatic int tag_bits(input int aw, input int sets);
    return aw - OFFSET_BITS - 2 - $clog2(sets);
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays for the data cache: one combinational lookup port and
// one write port (word write, tag+valid write, synchronous invalidate-all).
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int DW   = 32,
  parameter int IW   = 6,
  parameter int TW   = 22,
  parameter int SETS = 64
) (
  input  logic                   clk_i,
  input  logic                   inval_i,
  input  logic [IW-1:0]          lk_idx_i,
  input  logic [OFFSET_BITS-1:0] lk_off_i,
  output logic                   lk_valid_o,
  output logic [TW-1:0]          lk_tag_o,
  output logic [DW-1:0]          lk_word_o,
  input  logic                   wr_word_en_i,
  input  logic                   wr_tag_en_i,
  input  logic [IW-1:0]          wr_idx_i,
  input  logic [OFFSET_BITS-1:0] wr_off_i,
  input  logic [DW-1:0]          wr_data_i,
  input  logic [TW-1:0]          wr_tag_i
);

  logic [SETS-1:0]                      valid_q;
  logic [TW-1:0]                        tag_q  [SETS];
  logic [WORDS_PER_LINE-1:0][DW-1:0]    data_q [SETS];

  // Valid bits: invalidate-all beats a concurrent tag write so a line being
  // completed in a reset cycle still ends up invalid.
  always_ff @(posedge clk_i) begin
    if (inval_i)          valid_q <= '0;
    else if (wr_tag_en_i) valid_q[wr_idx_i] <= 1'b1;
  end

  // Tag and data arrays need no reset; they are only trusted behind valid.
  always_ff @(posedge clk_i) begin
    if (!inval_i && wr_tag_en_i)  tag_q[wr_idx_i] <= wr_tag_i;
    if (!inval_i && wr_word_en_i) data_q[wr_idx_i][wr_off_i] <= wr_data_i;
  end

  assign lk_valid_o = valid_q[lk_idx_i];
  assign lk_tag_o   = tag_q[lk_idx_i];
  assign lk_word_o  = data_q[lk_idx_i][lk_off_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache (4-word lines).
// Optional statistics counters are built when DCACHE_STATS_EN is defined.
module data_cache
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ren_i,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
);

  localparam int IW = idx_bits(SETS);
  localparam int TW = tag_bits(ADDR_WIDTH, SETS);

  dcache_state_t          state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;

  logic [OFFSET_BITS-1:0] off;
  logic [IW-1:0]          idx;
  logic [TW-1:0]          tag;
  logic                   lk_valid, hit;
  logic [TW-1:0]          lk_tag;
  logic [DATA_WIDTH-1:0]  lk_word;
  logic                   wr_word_en, wr_tag_en;
  logic [OFFSET_BITS-1:0] wr_off;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   unused_byte_off;

  assign off = addr_i[3:2];
  assign idx = addr_i[4 +: IW];
  assign tag = addr_i[ADDR_WIDTH-1 -: TW];
  assign hit = lk_valid && (lk_tag == tag);
  assign unused_byte_off = ^addr_i[1:0];

  dcache_line_store #(
    .DW(DATA_WIDTH), .IW(IW), .TW(TW), .SETS(SETS)
  ) u_store (
    .clk_i       (clk_i),
    .inval_i     (rst_i),
    .lk_idx_i    (idx),
    .lk_off_i    (off),
    .lk_valid_o  (lk_valid),
    .lk_tag_o    (lk_tag),
    .lk_word_o   (lk_word),
    .wr_word_en_i(wr_word_en),
    .wr_tag_en_i (wr_tag_en),
    .wr_idx_i    (idx),
    .wr_off_i    (wr_off),
    .wr_data_i   (wr_data),
    .wr_tag_i    (tag)
  );

  // State and refill word counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, memory port and CPU-facing outputs.
  // In WRITE the stall drops in the ack cycle so the pipeline advances exactly
  // once; holding it would replay the same store from IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    wr_word_en  = 1'b0;
    wr_tag_en   = 1'b0;
    wr_off      = off;
    wr_data     = wdata_i;
    case (state_q)
      IDLE: begin
        if (wen_i) begin
          stall_o = 1'b1;
          state_d = WRITE;
        end else if (ren_i) begin
          if (hit) begin
            rdata_o = lk_word;
          end else begin
            stall_o = 1'b1;
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_i[ADDR_WIDTH-1:4], cnt_q, 2'b00};
        if (mem_ack_i) begin
          wr_word_en = 1'b1;
          wr_off     = cnt_q;
          wr_data    = mem_rdata_i;
          cnt_d      = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            wr_tag_en = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        rdata_o = lk_word;
        state_d = IDLE;
      end
      WRITE: begin
        stall_o     = !mem_ack_i;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata_o = wdata_i;
        if (mem_ack_i) begin
          wr_word_en = hit;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        idle_rd, stat_hit, stat_miss;

  assign idle_rd   = (state_q == IDLE) && ren_i && !wen_i;
  assign stat_hit  = idle_rd && hit;
  assign stat_miss = idle_rd && !hit;

  // Hits count IDLE read hits; misses count entries into REFILL.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (stat_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (stat_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache; counter expectations follow
// whether DCACHE_STATS_EN is defined.
module tb_data_cache;

`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i, ren_i, wen_i, mem_ack_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, hit_count_o, miss_count_o;
  logic        stall_o, mem_req_o, mem_we_o;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  data_cache dut (
    .clk_i(clk_i), .rst_i(rst_i), .ren_i(ren_i), .wen_i(wen_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_hits"}, hit_count_o, STATS ? 32'(exp_hits) : 32'd0);
    chk({tag, "_miss"}, miss_count_o, STATS ? 32'(exp_miss) : 32'd0);
  endtask

  // Read hit: data in the same cycle, no stall.
  task automatic read_hit(input logic [31:0] a, input logic [31:0] exp);
    ren_i = 1'b1; addr_i = a; #1;
    chk("hit_rdata", rdata_o, exp);
    chk("hit_stall", 32'(stall_o), 32'd0);
    tick();
    exp_hits++;
    ren_i = 1'b0; #1;
    chk_stats("after_hit");
  endtask

  // Read miss with an ack every request cycle; memory returns d0+word.
  task automatic read_miss(input logic [31:0] a, input logic [31:0] d0);
    int sc = 0;
    logic [31:0] ea;
    ren_i = 1'b1; addr_i = a; mem_ack_i = 1'b0; #1;
    chk("miss_detect_stall", 32'(stall_o), 32'd1);
    chk("miss_detect_req", 32'(mem_req_o), 32'd0);
    if (stall_o) sc++;
    tick();
    exp_miss++;
    for (int w = 0; w < 4; w++) begin
      mem_ack_i = 1'b1; mem_rdata_i = d0 + 32'(w); #1;
      ea = {a[31:4], 4'h0} + 32'(4 * w);
      chk("refill_req", 32'(mem_req_o), 32'd1);
      chk("refill_we", 32'(mem_we_o), 32'd0);
      chk("refill_addr", mem_addr_o, ea);
      if (stall_o) sc++;
      tick();
    end
    mem_ack_i = 1'b0; #1;
    chk("resp_rdata", rdata_o, d0 + 32'(a[3:2]));
    chk("resp_stall", 32'(stall_o), 32'd0);
    chk("resp_req", 32'(mem_req_o), 32'd0);
    chk("miss_stall_cycles", 32'(sc), 32'd5);
    chk_stats("resp");
    tick();
    ren_i = 1'b0;
  endtask

  initial begin
    int wc;
    rst_i = 1'b1; ren_i = 1'b0; wen_i = 1'b0; mem_ack_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_rdata_i = '0;
    tick(); tick();
    rst_i = 1'b0; #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_we", 32'(mem_we_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk_stats("rst");

    // Fill line at 0x100, then hit on another word of it.
    read_miss(32'h100, 32'hA0);
    read_hit(32'h108, 32'hA2);

    // Store to a resident line, ack after 2 wait cycles.
    wen_i = 1'b1; addr_i = 32'h104; wdata_i = 32'hDEAD; #1;
    chk("st_detect_stall", 32'(stall_o), 32'd1);
    chk("st_detect_req", 32'(mem_req_o), 32'd0);
    tick();
    wc = 0;
    for (int c = 0; c < 3; c++) begin
      mem_ack_i = (c == 2); #1;
      chk("st_req", 32'(mem_req_o), 32'd1);
      chk("st_addr", mem_addr_o, 32'h104);
      chk("st_wdata", mem_wdata_o, 32'hDEAD);
      chk("st_stall", 32'(stall_o), (c == 2) ? 32'd0 : 32'd1);
      if (mem_we_o) wc++;
      tick();
    end
    mem_ack_i = 1'b0; wen_i = 1'b0; #1;
    chk("st_we_cycles", 32'(wc), 32'd3);
    chk("st_done_req", 32'(mem_req_o), 32'd0);
    read_hit(32'h104, 32'hDEAD);
    read_hit(32'h100, 32'hA0);

    // Store miss: write-through only, no allocation.
    wen_i = 1'b1; addr_i = 32'h2000; wdata_i = 32'h55; #1;
    chk("stm_detect_stall", 32'(stall_o), 32'd1);
    tick();
    mem_ack_i = 1'b1; #1;
    chk("stm_we", 32'(mem_we_o), 32'd1);
    chk("stm_addr", mem_addr_o, 32'h2000);
    chk("stm_wdata", mem_wdata_o, 32'h55);
    chk("stm_stall", 32'(stall_o), 32'd0);
    tick();
    mem_ack_i = 1'b0; wen_i = 1'b0; #1;
    chk("stm_idle_req", 32'(mem_req_o), 32'd0);
    chk("stm_idle_stall", 32'(stall_o), 32'd0);
    read_miss(32'h2000, 32'hB0);

    // Conflict on index 0x10: 0x500 evicts 0x100.
    read_hit(32'h100, 32'hA0);
    read_miss(32'h500, 32'hC0);
    read_hit(32'h504, 32'hC1);
    read_miss(32'h100, 32'hD0);

    // Reset after 2 acks into a refill.
    ren_i = 1'b1; addr_i = 32'h300; #1;
    chk("rr_detect_stall", 32'(stall_o), 32'd1);
    tick();
    for (int w = 0; w < 2; w++) begin
      mem_ack_i = 1'b1; mem_rdata_i = 32'hE0 + 32'(w); #1;
      chk("rr_addr", mem_addr_o, 32'h300 + 32'(4 * w));
      tick();
    end
    mem_ack_i = 1'b0; rst_i = 1'b1; ren_i = 1'b0;
    tick();
    rst_i = 1'b0; #1;
    exp_hits = 0; exp_miss = 0;
    chk("rr_req", 32'(mem_req_o), 32'd0);
    chk("rr_stall", 32'(stall_o), 32'd0);
    chk("rr_rdata", rdata_o, 32'd0);
    chk_stats("rr");
    ren_i = 1'b1; addr_i = 32'h300; #1;
    chk("rr_reread_miss", 32'(stall_o), 32'd1);
    addr_i = 32'h100; #1;
    chk("rr_other_miss", 32'(stall_o), 32'd1);
    ren_i = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
